nn_inference_ctrl: RTL and testbench

//  Sequencer in front of neural_net. Packs a word-serial sample stream into the

---
 rtl/nn_inference_ctrl_pkg.sv | 21 ++
 rtl/nn_inference_ctrl_timeout_ctr.sv | 29 ++
 rtl/nn_inference_ctrl.sv | 129 ++++++++++++
 tb/tb_nn_inference_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_inference_ctrl_pkg.sv
// Shared types and width helpers for the neural_net inference sequencer.
package nn_ctrl_pkg;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    FIRE = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } ctrl_state_t;

  localparam int unsigned DEF_IN_COUNT    = 4;
  localparam int unsigned DEF_TIMEOUT_CYC = 1024;
  localparam int unsigned DEF_IDX_W       = $clog2(DEF_IN_COUNT);
  localparam int unsigned DEF_TMR_W       = $clog2(DEF_TIMEOUT_CYC);

  // Index width that stays legal (>= 1 bit) for degenerate counts.
  function automatic int unsigned width_of(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nn_inference_ctrl_timeout_ctr.sv
// Watchdog counter: cleared on clear, counts while enabled, flags at TIMEOUT_CYC-1.
module nn_timeout_ctr #(
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter int unsigned W           = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYC - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + W'(1);
    end
  end

  assign expired = (count == LIMIT);

endmodule

// File: rtl/nn_inference_ctrl.sv
// Sequencer in front of neural_net: packs input words, fires, waits for done,
// returns the class result on a valid/ready port, and aborts hung inferences.
module nn_inference_ctrl
  import nn_ctrl_pkg::*;
#(
  parameter int unsigned IN_COUNT    = 4,
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned RESULT_W    = 4,
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           s_valid,
  output logic                           s_ready,
  input  logic [DATA_WIDTH-1:0]          s_data,
  output logic [IN_COUNT*DATA_WIDTH-1:0] nn_in,
  output logic                           nn_first,
  input  logic                           nn_done,
  input  logic [RESULT_W-1:0]            nn_result,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic [RESULT_W-1:0]            m_result,
  output logic                           busy,
  output logic                           timeout_err,
  output logic [CNT_W-1:0]               infer_cnt,
  output logic [CNT_W-1:0]               timeout_cnt,
  input  logic                           err_clr
);

  localparam int unsigned IDX_W = width_of(IN_COUNT);
  localparam int unsigned TMR_W = width_of(TIMEOUT_CYC);

  ctrl_state_t      state;
  logic [IDX_W-1:0] idx;
  logic             done_q;
  logic             expired;
  logic             last_word;
  logic             done_edge;
  logic             abort;

  assign s_ready   = (state == LOAD);
  assign busy      = (state != LOAD);
  assign last_word = (idx == IDX_W'(IN_COUNT - 1));
  assign done_edge = nn_done & ~done_q;
  // A coincident done edge beats the watchdog expiry.
  assign abort     = (state == WAIT) && !done_edge && expired;

  nn_timeout_ctr #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .W           (TMR_W)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state == FIRE),
    .enable  (state == WAIT),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= LOAD;
      idx       <= '0;
      nn_in     <= '0;
      nn_first  <= 1'b0;
      done_q    <= 1'b0;
      m_valid   <= 1'b0;
      m_result  <= '0;
      infer_cnt <= '0;
    end else begin
      nn_first <= 1'b0;
      case (state)
        LOAD: begin
          if (s_valid) begin
            nn_in[idx*DATA_WIDTH +: DATA_WIDTH] <= s_data;
            if (last_word) begin
              idx      <= '0;
              nn_first <= 1'b1;
              state    <= FIRE;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        FIRE: begin
          // Preload so a done level already high is not mistaken for an edge.
          done_q <= nn_done;
          state  <= WAIT;
        end
        WAIT: begin
          done_q <= nn_done;
          if (done_edge) begin
            m_result  <= nn_result;
            m_valid   <= 1'b1;
            infer_cnt <= infer_cnt + CNT_W'(1);
            state     <= HOLD;
          end else if (expired) begin
            state <= LOAD;
          end
        end
        HOLD: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            state   <= LOAD;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_err <= 1'b0;
      timeout_cnt <= '0;
    end else if (abort) begin
      timeout_err <= 1'b1;
      if (err_clr) begin
        timeout_cnt <= CNT_W'(1);
      end else if (!(&timeout_cnt)) begin
        timeout_cnt <= timeout_cnt + CNT_W'(1);
      end
    end else if (err_clr) begin
      timeout_err <= 1'b0;
      timeout_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_nn_inference_ctrl.sv
// Scoreboard bench for nn_inference_ctrl with a small behavioural neural_net model.
module tb_nn_inference_ctrl;

  localparam int unsigned IC = 4;
  localparam int unsigned DW = 16;
  localparam int unsigned RW = 4;
  localparam int unsigned TO = 64;
  localparam int unsigned CW = 16;

  typedef struct packed {
    logic [RW-1:0] res;
    logic [CW-1:0] cnt;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             s_valid;
  logic             s_ready;
  logic [DW-1:0]    s_data;
  logic [IC*DW-1:0] nn_in;
  logic             nn_first;
  logic             nn_done;
  logic [RW-1:0]    nn_result;
  logic             m_valid;
  logic             m_ready;
  logic [RW-1:0]    m_result;
  logic             busy;
  logic             timeout_err;
  logic [CW-1:0]    infer_cnt;
  logic [CW-1:0]    timeout_cnt;
  logic             err_clr;

  int   n_cmp = 0;
  int   n_err = 0;
  int   hs_cnt = 0;
  int   acc_cnt = 0;
  exp_t exp_q[$];

  // model_mode: 0 respond after model_delay, 1 done stuck high, 2 silent
  int model_mode  = 0;
  int model_delay = 3;
  int model_force = -1;

  logic [DW-1:0] stream [12];

  nn_inference_ctrl #(
    .IN_COUNT    (IC),
    .DATA_WIDTH  (DW),
    .RESULT_W    (RW),
    .TIMEOUT_CYC (TO),
    .CNT_W       (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .nn_in       (nn_in),
    .nn_first    (nn_first),
    .nn_done     (nn_done),
    .nn_result   (nn_result),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_result    (m_result),
    .busy        (busy),
    .timeout_err (timeout_err),
    .infer_cnt   (infer_cnt),
    .timeout_cnt (timeout_cnt),
    .err_clr     (err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model result: word0 low nibble xor word3 low nibble, unless forced.
  initial begin
    nn_done   = 1'b0;
    nn_result = '0;
    forever begin
      @(negedge clk);
      if (model_mode == 1) begin
        nn_done = 1'b1;
      end else if (nn_first) begin
        nn_done = 1'b0;
        if (model_mode == 0) begin
          repeat (model_delay) @(posedge clk);
          #1;
          nn_done   = 1'b1;
          nn_result = (model_force >= 0) ? RW'(model_force) : (nn_in[3:0] ^ nn_in[51:48]);
        end
      end
    end
  end

  // Monitor: counts word accepts and checks every result handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (s_valid && s_ready) acc_cnt++;
      if (m_valid && m_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_result: m_result=%0h infer_cnt=%0d with nothing expected", m_result, infer_cnt);
        end else begin
          e = exp_q.pop_front();
          chk("m_result", 64'(m_result), 64'(e.res));
          chk("infer_cnt", 64'(infer_cnt), 64'(e.cnt));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, hs=%0d", hs_cnt);
    $fatal(1);
  end

  task automatic send_words(input int n);
    int   p;
    logic acc;
    p = 0;
    @(posedge clk);
    #1;
    s_valid = 1'b1;
    s_data  = stream[0];
    for (int c = 0; c < 500 && p < n; c++) begin
      @(negedge clk);
      acc = s_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        p++;
        s_data = (p < n) ? stream[p] : '0;
      end
    end
    s_valid = 1'b0;
    if (p < n) chk("send_words_stall", 64'(p), 64'(n));
  endtask

  task automatic wait_hs(input int target, input string name);
    for (int i = 0; i < 400 && hs_cnt < target; i++) @(posedge clk);
    chk(name, 64'(hs_cnt), 64'(target));
  endtask

  task automatic set4(input logic [DW-1:0] a, b, c, d);
    stream[0] = a; stream[1] = b; stream[2] = c; stream[3] = d;
  endtask

  initial begin
    int a0;
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b1;
    err_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    @(negedge clk);
    chk("rst_nn_in", nn_in, 64'h0);
    chk("rst_nn_first", 64'(nn_first), 64'h0);
    chk("rst_m_valid", 64'(m_valid), 64'h0);
    chk("rst_m_result", 64'(m_result), 64'h0);
    chk("rst_timeout_err", 64'(timeout_err), 64'h0);
    chk("rst_counts", {32'(infer_cnt), 32'(timeout_cnt)}, 64'h0);
    chk("rst_ready_busy", {62'h0, s_ready, busy}, 64'h2);

    // 1/2: pack, fire, result 7 after 20 cycles, held under backpressure
    model_mode = 0; model_delay = 20; model_force = 7;
    m_ready = 1'b0;
    exp_q.push_back('{res: 4'd7, cnt: 16'd1});
    set4(16'h0800, 16'h1000, 16'hF800, 16'h0001);
    send_words(4);
    @(negedge clk);
    chk("t1_nn_first_on", 64'(nn_first), 64'h1);
    chk("t1_nn_in", nn_in, 64'h0001_F800_1000_0800);
    @(negedge clk);
    chk("t1_nn_first_off", 64'(nn_first), 64'h0);
    repeat (19) @(negedge clk);
    chk("t2_m_valid_early", 64'(m_valid), 64'h0);
    @(negedge clk);
    chk("t2_m_valid", 64'(m_valid), 64'h1);
    chk("t2_m_result", 64'(m_result), 64'h7);
    chk("t2_infer_cnt", 64'(infer_cnt), 64'h1);
    a0 = acc_cnt;
    s_valid = 1'b1;
    s_data  = 16'hDEAD;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t2_hold", {51'h0, m_valid, m_result, s_ready, nn_first, busy, 4'(infer_cnt)},
          {51'h0, 1'b1, 4'h7, 1'b0, 1'b0, 1'b1, 4'h1});
    end
    chk("t2_no_accept_in_hold", 64'(acc_cnt - a0), 64'h0);
    chk("t2_nn_in_stable", nn_in, 64'h0001_F800_1000_0800);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    m_ready = 1'b1;
    wait_hs(1, "t2_handshake");
    @(negedge clk);
    chk("t2_back_to_load", {62'h0, busy, m_valid}, 64'h0);

    // 3: stale done level never toggles -> watchdog abort after TO wait cycles
    model_mode = 1;
    set4(16'h1111, 16'h2222, 16'h3333, 16'h4444);
    send_words(4);
    @(negedge clk);
    chk("t3_first", 64'(nn_first), 64'h1);
    repeat (TO) @(negedge clk);
    chk("t3_still_waiting", {62'h0, busy, timeout_err}, 64'h2);
    @(negedge clk);
    chk("t3_timeout_err", 64'(timeout_err), 64'h1);
    chk("t3_timeout_cnt", 64'(timeout_cnt), 64'h1);
    chk("t3_idle", {62'h0, busy, m_valid}, 64'h0);

    // 4: done edge exactly on the expiry cycle -> captured
    model_mode = 0; model_delay = TO; model_force = 10;
    exp_q.push_back('{res: 4'hA, cnt: 16'd2});
    set4(16'h0005, 16'h0006, 16'h0007, 16'h0008);
    send_words(4);
    @(negedge clk);
    repeat (TO) @(negedge clk);
    chk("t4_no_valid_yet", 64'(m_valid), 64'h0);
    @(negedge clk);
    chk("t4_m_valid", 64'(m_valid), 64'h1);
    wait_hs(2, "t4_handshake");
    chk("t4_timeout_cnt", 64'(timeout_cnt), 64'h1);
    chk("t4_timeout_err", 64'(timeout_err), 64'h1);

    // timeout coinciding with err_clr: timeout wins, count restarts at 1
    model_mode = 1;
    send_words(4);
    @(negedge clk);
    repeat (TO - 1) @(negedge clk);
    @(posedge clk);
    #1 err_clr = 1'b1;
    @(posedge clk);
    #1 err_clr = 1'b0;
    @(negedge clk);
    chk("clr_vs_timeout", {62'h0, timeout_err, busy}, 64'h2);
    chk("clr_vs_timeout_cnt", 64'(timeout_cnt), 64'h1);
    @(posedge clk);
    #1 err_clr = 1'b1;
    @(posedge clk);
    #1 err_clr = 1'b0;
    @(negedge clk);
    chk("err_clr", {32'(timeout_err), 32'(timeout_cnt)}, 64'h0);

    // 5: back-to-back, s_valid and m_ready held high for three inferences
    model_mode = 0; model_delay = 3; model_force = -1;
    stream[0] = 16'h0011; stream[1]  = 16'h0022; stream[2]  = 16'h0033; stream[3]  = 16'h0044;
    stream[4] = 16'h000A; stream[5]  = 16'h1111; stream[6]  = 16'h2222; stream[7]  = 16'h0003;
    stream[8] = 16'h000F; stream[9]  = 16'h0000; stream[10] = 16'h0000; stream[11] = 16'h0008;
    exp_q.push_back('{res: 4'h5, cnt: 16'd3});
    exp_q.push_back('{res: 4'h9, cnt: 16'd4});
    exp_q.push_back('{res: 4'h7, cnt: 16'd5});
    a0 = acc_cnt;
    send_words(12);
    wait_hs(5, "t5_handshakes");
    chk("t5_words_consumed", 64'(acc_cnt - a0), 64'd12);
    chk("t5_infer_cnt", 64'(infer_cnt), 64'd5);
    chk("t5_last_nn_in", nn_in, 64'h0008_0000_0000_000F);

    // 6: reset during WAIT, then a clean inference
    model_mode = 2;
    set4(16'h0001, 16'h0002, 16'h0003, 16'h0004);
    send_words(4);
    repeat (6) @(negedge clk);
    chk("t6_in_wait", 64'(busy), 64'h1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("t6_reset_nn_in", nn_in, 64'h0);
    chk("t6_reset_state", {60'h0, busy, m_valid, timeout_err, s_ready}, 64'h1);
    chk("t6_reset_counts", {32'(infer_cnt), 32'(timeout_cnt)}, 64'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_mode = 0; model_delay = 5; model_force = -1;
    exp_q.push_back('{res: 4'h5, cnt: 16'd1});
    set4(16'h0003, 16'h0000, 16'h0000, 16'h0006);
    send_words(4);
    wait_hs(6, "t6_handshake");
    chk("t6_nn_in", nn_in, 64'h0006_0000_0000_0003);

    repeat (3) @(negedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
